// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Writer side of the instruction memory. Receives a framed byte stream from a
// serial byte receiver and writes 32-bit words sequentially into the write port
// of instr_mem. While a frame is in progress cpu_hold is raised; the top level
// ORs it into the processor reset so the pipeline restarts on the new program.
//
// Frame: 0xA5 (sync), N (word count), 4*N data bytes MSB first, [checksum].
//
// Build option:
//   PROG_LOADER_CHECKSUM_EN  when defined, a trailing byte equal to the XOR of
//                            all data bytes is required before done is raised.
//                            When undefined, the frame ends after the last word
//                            and any trailing byte is ignored.
//
// Parameters:
//   ADDR_W   word-address width, capacity 2**ADDR_W words
//   TIMEOUT  max idle cycles between bytes inside a frame before aborting
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   start       level; loader armed while high
//   rx_data     received byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   mem_addr    word address for instr_mem writes
//   mem_data    write data
//   mem_wren    one-cycle write strobe
//   cpu_hold    high while a frame is in progress
//   done        high after a successful load until start falls
//   error       high after an aborted frame until start falls
//   word_count  words written in the current or last frame
// -----------------------------------------------------------------------------
module prog_loader #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic              mem_wren,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   localparam int unsigned CntW     = ADDR_W + 1;
   localparam int unsigned TmrW     = $clog2(TIMEOUT + 1);
   localparam int unsigned Cap      = 2 ** ADDR_W;
   localparam logic [7:0]  SyncByte = 8'hA5;

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StLen,
      StData,
`ifdef PROG_LOADER_CHECKSUM_EN
      StChk,
`endif
      StDone,
      StErr
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_data_q;
   logic              mem_wren_q;
   logic              cpu_hold_q;
   logic              done_q;
   logic              error_q;
   logic [CntW-1:0]   word_count_q;
   logic [CntW-1:0]   len_q;
   logic [23:0]       shift_q;     // first three bytes of the word being assembled
   logic [1:0]        byte_idx_q;
   logic [TmrW-1:0]   timer_q;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic [TmrW-1:0]   timer_d;
   logic [CntW-1:0]   word_count_d;
   logic [31:0]       word_d;
   logic              in_frame;
   logic              frame_full;
   logic              abort;

   always_comb begin
      timer_d      = timer_q + TmrW'(1);
      word_count_d = word_count_q + CntW'(1);
      word_d       = {shift_q, rx_data};
      in_frame     = (state_q == StLen) || (state_q == StData);
`ifdef PROG_LOADER_CHECKSUM_EN
      in_frame     = in_frame || (state_q == StChk);
`endif
      frame_full   = (word_count_q == len_q);
      // Dropping start or running out of idle time kills the frame outright.
      abort        = in_frame &&
                     (!start || (!rx_valid && (timer_d == TmrW'(TIMEOUT))));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_wren_q   <= 1'b0;
         cpu_hold_q   <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         word_count_q <= '0;
         len_q        <= '0;
         shift_q      <= '0;
         byte_idx_q   <= '0;
         timer_q      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         mem_wren_q <= 1'b0;
         // After a strobe, advance to the next free word; wraps only after the
         // final write of a full-capacity frame.
         if (mem_wren_q) begin
            mem_addr_q <= word_count_q[ADDR_W-1:0];
         end

         if (abort) begin
            // Taking this branch skips the DATA write, suppressing any pending strobe.
            state_q    <= StErr;
            cpu_hold_q <= 1'b0;
            error_q    <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start) begin
                     state_q      <= StSync;
                     done_q       <= 1'b0;
                     error_q      <= 1'b0;
                     word_count_q <= '0;
                     mem_addr_q   <= '0;
                  end
               end

               StSync: begin
                  cpu_hold_q <= 1'b0;
                  if (!start) begin
                     state_q <= StIdle;
                  end else if (rx_valid && (rx_data == SyncByte)) begin
                     state_q    <= StLen;
                     cpu_hold_q <= 1'b1;
                     timer_q    <= '0;
                  end
               end

               StLen: begin
                  if (rx_valid) begin
                     timer_q <= '0;
                     if ((rx_data == 8'h00) || (32'(rx_data) > Cap)) begin
                        state_q    <= StErr;
                        cpu_hold_q <= 1'b0;
                        error_q    <= 1'b1;
                     end else begin
                        state_q    <= StData;
                        len_q      <= CntW'(rx_data);
                        byte_idx_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                     end
                  end else begin
                     timer_q <= timer_d;
                  end
               end

               StData: begin
                  if (frame_full) begin
                     // Last strobe is on the bus this cycle; done follows it.
                     state_q    <= StDone;
                     cpu_hold_q <= 1'b0;
                     done_q     <= 1'b1;
                  end else if (rx_valid) begin
                     timer_q    <= '0;
                     shift_q    <= word_d[23:0];
                     byte_idx_q <= byte_idx_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                     csum_q     <= csum_q ^ rx_data;
`endif
                     if (byte_idx_q == 2'd3) begin
                        mem_wren_q   <= 1'b1;
                        mem_data_q   <= word_d;
                        mem_addr_q   <= word_count_q[ADDR_W-1:0];
                        word_count_q <= word_count_d;
`ifdef PROG_LOADER_CHECKSUM_EN
                        // Enter CHK alongside the strobe so a back-to-back
                        // checksum byte is not lost.
                        if (word_count_d == len_q) begin
                           state_q <= StChk;
                        end
`endif
                     end
                  end else begin
                     timer_q <= timer_d;
                  end
               end

`ifdef PROG_LOADER_CHECKSUM_EN
               StChk: begin
                  if (rx_valid) begin
                     timer_q    <= '0;
                     cpu_hold_q <= 1'b0;
                     if (rx_data == csum_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= StErr;
                        error_q <= 1'b1;
                     end
                  end else begin
                     timer_q <= timer_d;
                  end
               end
`endif

               StDone: begin
                  cpu_hold_q <= 1'b0;
                  if (!start) begin
                     state_q <= StIdle;
                     done_q  <= 1'b0;
                  end
               end

               StErr: begin
                  cpu_hold_q <= 1'b0;
                  if (!start) begin
                     state_q <= StIdle;
                     error_q <= 1'b0;
                  end
               end

               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign mem_wren   = mem_wren_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader: directed bench for prog_loader (ADDR_W=5, TIMEOUT=16).
// Bytes are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_prog_loader;

   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned TIMEOUT = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;
   logic              mem_wren;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   prog_loader #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_wren   (mem_wren),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Write log captured from the memory port.
   int                wr_n = 0;
   logic [ADDR_W-1:0] wr_addr [128];
   logic [31:0]       wr_data [128];
   logic              overlap = 1'b0;

   always @(negedge clock) begin
      if (mem_wren) begin
         if (wr_n < 128) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_data;
         end
         wr_n = wr_n + 1;
         if (done) overlap = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic wait_end();
      for (int i = 0; i < 64; i++) begin
         if (done || error) break;
         @(negedge clock);
      end
   endtask

   task automatic arm();
      start = 1'b1;
      @(negedge clock);
   endtask

   task automatic disarm();
      start = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   int          base;
   int          bad;
   logic [31:0] exp_word;

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clock);
      check("rst_wren", mem_wren, 0);
      check("rst_hold", cpu_hold, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_count", word_count, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_data, 0);
      reset = 1'b0;
      @(negedge clock);

      // Normal two-word load.
      base = wr_n;
      arm();
      check("t1_hold_sync", cpu_hold, 0);
      send(8'hA5);
      check("t1_hold_frame", cpu_hold, 1);
      send(8'h02);
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      send(8'h00); send(8'h00); send(8'h00); send(8'h2A);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'h08);  // XOR of the eight data bytes
`endif
      wait_end();
      check("t1_nwr", wr_n - base, 2);
      check("t1_addr0", wr_addr[base], 0);
      check("t1_data0", wr_data[base], 32'hDEADBEEF);
      check("t1_addr1", wr_addr[base+1], 1);
      check("t1_data1", wr_data[base+1], 32'h0000002A);
      check("t1_done", done, 1);
      check("t1_error", error, 0);
      check("t1_count", word_count, 2);
      check("t1_hold_end", cpu_hold, 0);
      check("t1_overlap", overlap, 0);
      disarm();
      check("t1_done_clr", done, 0);

      // Bad LEN: zero, then one beyond capacity.
      base = wr_n;
      arm();
      send(8'hA5);
      send(8'h00);
      check("t2_err_len0", error, 1);
      check("t2_hold_len0", cpu_hold, 0);
      disarm();
      check("t2_err_clr", error, 0);
      arm();
      send(8'hA5);
      send(8'h21);
      check("t2_err_len33", error, 1);
      check("t2_nwr", wr_n - base, 0);
      disarm();

      // Garbage ahead of sync.
      base = wr_n;
      arm();
      send(8'h13);
      check("t3_hold_g1", cpu_hold, 0);
      send(8'h37);
      check("t3_hold_g2", cpu_hold, 0);
      send(8'hA5);
      check("t3_hold_sync", cpu_hold, 1);
      send(8'h01);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'h04);
`endif
      wait_end();
      check("t3_nwr", wr_n - base, 1);
      check("t3_addr", wr_addr[base], 0);
      check("t3_data", wr_data[base], 32'h01020304);
      check("t3_done", done, 1);
      check("t3_count", word_count, 1);
      disarm();

      // Timeout: error rises on the 16th edge after the last accepted byte.
      base = wr_n;
      arm();
      send(8'hA5); send(8'h01); send(8'h11); send(8'h22);
      repeat (15) @(negedge clock);
      check("t4_err_early", error, 0);
      @(negedge clock);
      check("t4_err_tmo", error, 1);
      check("t4_nwr", wr_n - base, 0);
      disarm();
      check("t4_err_idle", error, 0);
      arm();
      check("t4_err_rearm", error, 0);
      check("t4_hold_rearm", cpu_hold, 0);
      disarm();

      // Trailing byte: checksum mismatch when enabled, ignored otherwise.
      base = wr_n;
      arm();
      send(8'hA5); send(8'h01);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'hFF);
      wait_end();
      check("t5_nwr", wr_n - base, 1);
      check("t5_data", wr_data[base], 32'h01020304);
`ifdef PROG_LOADER_CHECKSUM_EN
      check("t5_err_bad", error, 1);
      check("t5_done_bad", done, 0);
      disarm();
      arm();
      send(8'hA5); send(8'h01);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h04);
      wait_end();
      check("t5_done_good", done, 1);
      check("t5_err_good", error, 0);
`else
      check("t5_done", done, 1);
      check("t5_err", error, 0);
`endif
      disarm();

      // Full capacity: 32 words, address wraps only after the last write.
      base = wr_n;
      arm();
      send(8'hA5);
      send(8'h20);
      for (int i = 0; i < 128; i++) send(8'(i));
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'h00);  // XOR of 0..127
`endif
      wait_end();
      check("t6_nwr", wr_n - base, 32);
      bad = 0;
      for (int w = 0; w < 32; w++) begin
         exp_word = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
         if ((wr_addr[base+w] !== 5'(w)) || (wr_data[base+w] !== exp_word)) bad++;
      end
      check("t6_seq_bad", bad, 0);
      check("t6_last_addr", wr_addr[base+31], 31);
      check("t6_last_data", wr_data[base+31], 32'h7C7D7E7F);
      check("t6_count", word_count, 32);
      check("t6_addr_wrap", mem_addr, 0);
      check("t6_done", done, 1);
      disarm();

      // Reset after the second data byte, then a fresh frame with start held.
      base = wr_n;
      arm();
      send(8'hA5); send(8'h01); send(8'hAA); send(8'hBB);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("t7_hold", cpu_hold, 0);
      check("t7_done", done, 0);
      check("t7_error", error, 0);
      check("t7_count", word_count, 0);
      check("t7_wren", mem_wren, 0);
      check("t7_addr", mem_addr, 0);
      check("t7_data", mem_data, 0);
      check("t7_nwr", wr_n - base, 0);
      @(negedge clock);
      send(8'hA5); send(8'h01);
      send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'h30);
`endif
      wait_end();
      check("t7_nwr2", wr_n - base, 1);
      check("t7_addr2", wr_addr[base], 0);
      check("t7_data2", wr_data[base], 32'hCAFEBABE);
      check("t7_done2", done, 1);
      disarm();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
